// File: rtl/wallace_pkg.sv
// Shared sizing helpers for the pipelined Wallace multiplier: row/layer counts,
// layer-to-stage mapping and the Baugh-Wooley correction constant.
package wallace_pkg;

  localparam int CORR_ROWS = 1;
  // Row count of the widest legal operand (32 partial products plus correction row).
  localparam int PP_ROWS = 32 + CORR_ROWS;

  function automatic int pp_rows(input int width);
    return width + CORR_ROWS;
  endfunction

  function automatic int rows_after(input int rows, input int layers);
    int n;
    n = rows;
    for (int k = 0; k < layers; k++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  function automatic int csa_layers(input int rows);
    int n;
    int l;
    n = rows;
    l = 0;
    for (int k = 0; k < 64; k++) begin
      if (n > 2) begin
        n = 2 * (n / 3) + (n % 3);
        l = l + 1;
      end
    end
    return l;
  endfunction

  // Even split of layers over stages; leftover layers land in the earliest stages.
  function automatic int first_layer(input int stage, input int stages, input int layers);
    int base;
    int rem;
    base = layers / stages;
    rem  = layers % stages;
    return stage * base + ((stage < rem) ? stage : rem);
  endfunction

  function automatic int stage_of_layer(input int layer, input int stages, input int width);
    int nl;
    int st;
    nl = csa_layers(pp_rows(width));
    st = 0;
    for (int s = 0; s < stages; s++) begin
      if (layer >= first_layer(s, stages, nl)) begin
        st = s;
      end
    end
    return st;
  endfunction

  // Folds the two negated sign-row/column terms into 2^W + 2^(2W-1).
  function automatic logic [63:0] bw_corr(input int width);
    return (64'd1 << width) | (64'd1 << (2 * width - 1));
  endfunction

endpackage

// File: rtl/wallace_mult_pipe_csa_row.sv
// One row of 3:2 carry-save compressors; the carry vector comes out pre-shifted
// by one place and truncated to the row width.
module csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = {(x[N-2:0] & y[N-2:0]) | (x[N-2:0] & z[N-2:0]) | (y[N-2:0] & z[N-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined WIDTH x WIDTH Wallace-tree multiplier with signed/unsigned mode and
// valid/ready flow control; CSA layers are spread over STAGES register stages.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 3,
  parameter int SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);

  localparam int P     = 2 * WIDTH;
  localparam int NROWS = pp_rows(WIDTH);
  localparam int NL    = csa_layers(NROWS);
  localparam logic [63:0] CORR64 = bw_corr(WIDTH);

  logic [STAGES-1:0]         v_r;
  logic [STAGES-1:0]         adv_s;
  logic [STAGES-1:0]         vin_s;
  logic                      sgn_s;
  logic [NROWS-1:0][P-1:0]   pp_s;
  logic [1:0][P-1:0]         fin_s;

  assign sgn_s     = (SIGNED_EN != 0) ? is_signed : 1'b0;
  assign in_ready  = adv_s[0];
  assign out_valid = v_r[STAGES-1];

  // Stage k may advance if it or any stage below it is empty, or the consumer takes prod.
  always_comb begin
    vin_s    = '0;
    adv_s    = '0;
    vin_s[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      vin_s[k] = v_r[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      adv_s[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        adv_s[k] = adv_s[k] | ~v_r[j];
      end
    end
  end

  // Partial products: sign row/column bits inverted in signed mode, plus correction row.
  always_comb begin
    pp_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_s[i][i + j] = (a[j] & b[i]) ^ (sgn_s & ((i == WIDTH - 1) ^ (j == WIDTH - 1)));
      end
    end
    pp_s[NROWS-1] = sgn_s ? CORR64[P-1:0] : '0;
  end

  for (genvar L = 0; L < NL; L++) begin : lay
    localparam int NI = rows_after(NROWS, L);
    localparam int NG = NI / 3;
    localparam int NO = 2 * NG + (NI % 3);
    localparam int ST = stage_of_layer(L, STAGES, WIDTH);
    logic [NI-1:0][P-1:0] li;
    logic [NO-1:0][P-1:0] lo;

    if (L == 0) begin : g_from_pp
      assign li = pp_s;
    end else if (L == first_layer(ST, STAGES, NL)) begin : g_from_reg
      assign li = stg[ST].q;
    end else begin : g_from_layer
      assign li = lay[L-1].lo;
    end

    for (genvar g = 0; g < NG; g++) begin : grp
      csa_row #(.N(P)) u_csa (
        .x (li[3*g]),
        .y (li[3*g+1]),
        .z (li[3*g+2]),
        .s (lo[2*g]),
        .c (lo[2*g+1])
      );
    end
    for (genvar r = 0; r < NI % 3; r++) begin : pass
      assign lo[2*NG + r] = li[3*NG + r];
    end
  end

  for (genvar s = 1; s < STAGES; s++) begin : stg
    localparam int FS = first_layer(s, STAGES, NL);
    localparam int NR = rows_after(NROWS, FS);
    logic [NR-1:0][P-1:0] d;
    logic [NR-1:0][P-1:0] q;

    if (first_layer(s - 1, STAGES, NL) == FS) begin : g_empty_prev
      assign d = stg[s-1].q;
    end else begin : g_layer_prev
      assign d = lay[FS-1].lo;
    end

    // Carry-save rows between stages; only loaded when real data moves in.
    always_ff @(posedge clk) begin
      if (adv_s[s-1] && vin_s[s-1]) begin
        q <= d;
      end
    end
  end

  if ((STAGES > 1) && (first_layer(STAGES - 1, STAGES, NL) == NL)) begin : g_fin_reg
    assign fin_s = stg[STAGES-1].q;
  end else begin : g_fin_layer
    assign fin_s = lay[NL-1].lo;
  end

  // Per-stage valid bits; reset drops every in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv_s[k]) begin
          v_r[k] <= vin_s[k];
        end
      end
    end
  end

  // Final carry-propagate add into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
    end else if (adv_s[STAGES-1] && vin_s[STAGES-1]) begin
      prod <= fin_s[0] + fin_s[1];
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench: 8-bit/3-stage and 16-bit/4-stage instances against an
// arithmetic reference model with queue scoreboards.
module tb_wallace_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv16, ir16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  wallace_mult_pipe #(.WIDTH(8), .STAGES(3), .SIGNED_EN(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .prod(p8)
  );

  wallace_mult_pipe #(.WIDTH(16), .STAGES(4), .SIGNED_EN(1)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .prod(p16)
  );

  function automatic longint ref_mul(input longint av, input longint bv, input bit s, input int w);
    longint sa, sb, m;
    sa = av;
    sb = bv;
    if (s) begin
      if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    end
    m = (longint'(1) << (2 * w)) - longint'(1);
    return (sa * sb) & m;
  endfunction

  // One cycle on the 8-bit instance: drive at negedge, then report handshakes and scoreboard data.
  task automatic step8(input bit iv, input logic [7:0] a, input logic [7:0] b, input bit s,
                       input bit ordy, output bit acc, output bit outx,
                       output logic [15:0] got, output logic [15:0] ev, output bit qe);
    longint r;
    @(negedge clk);
    iv8 = iv; a8 = a; b8 = b; s8 = s; or8 = ordy;
    #1;
    acc  = iv8 && ir8;
    outx = ov8 && or8;
    got  = p8;
    ev   = 16'h0000;
    qe   = 1'b0;
    if (outx) begin
      if (q8.size() == 0) qe = 1'b1;
      else ev = q8.pop_front();
    end
    if (acc) begin
      r = ref_mul(longint'(a), longint'(b), s, 8);
      q8.push_back(r[15:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; s8 = 1'b0; or8 = 1'b1;
    iv16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; s16 = 1'b0; or16 = 1'b1;
    #12 rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ov8); end
    n_checks++; if (p8 !== 16'h0000) begin n_fail++; $display("FAIL reset_prod: got %h want 0000", p8); end
    n_checks++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", ir8); end
    n_checks++; if (ov16 !== 1'b0 || p16 !== 32'h0 || ir16 !== 1'b1) begin
      n_fail++; $display("FAIL reset_u16: ov=%b prod=%h ir=%b want 0/0/1", ov16, p16, ir16);
    end
  endtask

  task automatic test_latency();
    bit acc, outx, qe;
    logic [15:0] got, ev;
    step8(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, acc, outx, got, ev, qe);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL lat_accept: got %b want 1", acc); end
    for (int k = 1; k <= 3; k++) begin
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, outx, got, ev, qe);
      n_checks++;
      if (outx !== (k == 3)) begin n_fail++; $display("FAIL lat_valid edge %0d: got %b want %b", k, outx, (k == 3)); end
      if (k == 3) begin
        n_checks++;
        if (got !== 16'hFE01) begin n_fail++; $display("FAIL lat_prod: got %h want FE01", got); end
      end
    end
  endtask

  task automatic test_signed();
    logic [7:0]  ta[3] = '{8'h80, 8'hFF, 8'hFF};
    logic [7:0]  tb[3] = '{8'h80, 8'h7F, 8'h7F};
    bit          ts[3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] tp[3] = '{16'h4000, 16'hFF81, 16'h7E81};
    bit acc, outx, qe;
    logic [15:0] got, ev;
    int idx, last;
    idx = 0; last = -1;
    for (int i = 0; i < 12; i++) begin
      if (i < 3) step8(1'b1, ta[i], tb[i], ts[i], 1'b1, acc, outx, got, ev, qe);
      else       step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, outx, got, ev, qe);
      if (outx && idx < 3) begin
        n_checks++;
        if (got !== tp[idx]) begin n_fail++; $display("FAIL signed_prod %0d: got %h want %h", idx, got, tp[idx]); end
        if (idx > 0) begin
          n_checks++;
          if (i != last + 1) begin n_fail++; $display("FAIL signed_b2b %0d: gap got %0d want 1", idx, i - last); end
        end
        last = i;
        idx++;
      end
    end
    n_checks++; if (idx !== 3) begin n_fail++; $display("FAIL signed_count: got %0d want 3", idx); end
  endtask

  task automatic test_sweep();
    logic [7:0] vals[9] = '{8'h00, 8'h01, 8'h02, 8'h7E, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    bit acc, outx, qe;
    logic [15:0] got, ev;
    logic [7:0] a, b;
    bit s;
    int n, res;
    n = 162 + 3000;
    res = 0;
    for (int i = 0; i < n + 3; i++) begin
      if (i < 162) begin
        a = vals[(i % 81) / 9]; b = vals[i % 9]; s = (i >= 81);
      end else begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); s = 1'($urandom_range(0, 1));
      end
      step8(i < n, a, b, s, 1'b1, acc, outx, got, ev, qe);
      if (i < n) begin
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready at %0d: got %b want 1", i, acc); end
      end
      if (i >= 3) begin
        n_checks++;
        if (outx !== 1'b1) begin n_fail++; $display("FAIL sweep_rate at %0d: got %b want 1", i, outx); end
      end
      if (outx) begin
        res++;
        n_checks++;
        if (qe || got !== ev) begin n_fail++; $display("FAIL sweep_prod at %0d: got %h want %h (empty=%b)", i, got, ev, qe); end
      end
    end
    n_checks++; if (res !== n) begin n_fail++; $display("FAIL sweep_count: got %0d want %0d", res, n); end
  endtask

  task automatic test_backpressure();
    logic [7:0] oa[5], ob[5];
    bit os[5];
    bit acc, outx, qe, held_v;
    logic [15:0] got, ev, held;
    int idx, ci, res, last;
    for (int i = 0; i < 5; i++) begin
      oa[i] = 8'($urandom_range(1, 255)); ob[i] = 8'($urandom_range(1, 255)); os[i] = (i % 2 == 1);
    end
    idx = 0; held_v = 1'b0; held = 16'h0000;
    for (int c = 0; c < 6; c++) begin
      ci = (idx < 5) ? idx : 4;
      step8(idx < 5, oa[ci], ob[ci], os[ci], 1'b0, acc, outx, got, ev, qe);
      if (held_v) begin
        n_checks++;
        if (ov8 !== 1'b1 || p8 !== held) begin
          n_fail++; $display("FAIL bp_stable cycle %0d: ov=%b prod=%h want 1/%h", c, ov8, p8, held);
        end
      end else if (ov8 === 1'b1) begin
        held_v = 1'b1; held = p8;
      end
      if (acc) idx++;
    end
    n_checks++; if (idx !== 3) begin n_fail++; $display("FAIL bp_accepts: got %0d want 3", idx); end
    n_checks++; if (ir8 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", ir8); end
    res = 0; last = -1;
    for (int c = 0; c < 12; c++) begin
      ci = (idx < 5) ? idx : 4;
      step8(idx < 5, oa[ci], ob[ci], os[ci], 1'b1, acc, outx, got, ev, qe);
      if (c == 0) begin
        n_checks++;
        if (acc !== 1'b1 || outx !== 1'b1) begin n_fail++; $display("FAIL bp_full_swap: acc=%b out=%b want 1/1", acc, outx); end
      end
      if (acc) idx++;
      if (outx) begin
        n_checks++;
        if (qe || got !== ev) begin n_fail++; $display("FAIL bp_prod %0d: got %h want %h", res, got, ev); end
        res++; last = c;
      end
    end
    n_checks++; if (res !== 5 || last !== 4) begin n_fail++; $display("FAIL bp_drain: results %0d last %0d want 5/4", res, last); end
  endtask

  task automatic test_reset_mid();
    bit acc, outx, qe, seen;
    logic [15:0] got, ev;
    step8(1'b1, 8'h35, 8'h4B, 1'b1, 1'b0, acc, outx, got, ev, qe);
    step8(1'b1, 8'hC3, 8'h27, 1'b0, 1'b0, acc, outx, got, ev, qe);
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc, outx, got, ev, qe);
      seen = (ov8 === 1'b1);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rm_fill: out_valid got 0 want 1 within bound"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b want 0", ov8); end
    n_checks++; if (p8 !== 16'h0000) begin n_fail++; $display("FAIL rm_prod: got %h want 0000", p8); end
    #3 rst_n = 1'b1;
    q8.delete();
    q16.delete();
    for (int c = 0; c < 10; c++) begin
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, outx, got, ev, qe);
      n_checks++;
      if (outx !== 1'b0) begin n_fail++; $display("FAIL rm_stale cycle %0d: got out %b prod %h want no output", c, outx, got); end
    end
  endtask

  task automatic test_stress16();
    bit stall;
    logic [31:0] prev, ev;
    longint r;
    int acc_n, out_n;
    stall = 1'b0; prev = 32'h0; acc_n = 0; out_n = 0;
    for (int c = 0; c < 3060; c++) begin
      @(negedge clk);
      if (c < 3000) begin
        iv16 = 1'($urandom_range(0, 1)); or16 = 1'($urandom_range(0, 1));
      end else begin
        iv16 = 1'b0; or16 = 1'b1;
      end
      a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom_range(0, 1));
      #1;
      if (stall) begin
        n_checks++;
        if (ov16 !== 1'b1 || p16 !== prev) begin n_fail++; $display("FAIL st_stall cycle %0d: ov=%b prod=%h want 1/%h", c, ov16, p16, prev); end
      end
      stall = ov16 && !or16;
      prev  = p16;
      if (ov16 && or16) begin
        out_n++;
        n_checks++;
        if (q16.size() == 0) begin
          n_fail++; $display("FAIL st_extra cycle %0d: got prod %h want no output", c, p16);
        end else begin
          ev = q16.pop_front();
          if (p16 !== ev) begin n_fail++; $display("FAIL st_prod cycle %0d: got %h want %h", c, p16, ev); end
        end
      end
      if (iv16 && ir16) begin
        acc_n++;
        r = ref_mul(longint'(a16), longint'(b16), s16, 16);
        q16.push_back(r[31:0]);
      end
    end
    n_checks++;
    if (q16.size() != 0 || out_n != acc_n) begin
      n_fail++; $display("FAIL st_complete: outputs %0d pending %0d want accepted %0d/0", out_n, q16.size(), acc_n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_latency();
    test_signed();
    test_sweep();
    test_backpressure();
    test_reset_mid();
    test_stress16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
